// File: rtl/subtractor_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_seq_ctrl_pkg
// Description : Shared constants and state type for the multi-byte subtraction
//               sequencer. Ports: none (package).
// Revision    : 1.0 - initial release
// ============================================================================
package subtractor_seq_ctrl_pkg;

    // Width of one datapath slice.
    localparam int BYTE_W = 8;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage : subtractor_seq_ctrl_pkg
`default_nettype wire

// File: rtl/subtractor_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_seq_ctrl_if
// Description : Operand/handshake/result bundle of the subtraction sequencer.
//               master : drives start, abort, A, B, borrow_in; observes results
//               slave  : the sequencer side (consumes requests, drives results)
// Revision    : 1.0 - initial release
// ============================================================================
interface subtractor_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    import subtractor_seq_ctrl_pkg::*;

    logic                       start;
    logic                       abort;
    logic [BYTE_W*NBYTES-1:0]   A;
    logic [BYTE_W*NBYTES-1:0]   B;
    logic                       borrow_in;
    logic                       ready;
    logic                       busy;
    logic                       done;
    logic [BYTE_W*NBYTES-1:0]   diff;
    logic                       borrow_out;
    logic                       zero;

    modport master (
        output start, abort, A, B, borrow_in,
        input  ready, busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, abort, A, B, borrow_in,
        output ready, busy, done, diff, borrow_out, zero
    );

endinterface : subtractor_seq_ctrl_if
`default_nettype wire

// File: rtl/subtractor_seq_ctrl_sub8.sv
`default_nettype none
// ============================================================================
// Module      : Subtractor_8_bit
// Description : Combinational 8-bit ripple subtractor: d = a - b - bin.
//               Ports: a, b (8-bit operands), bin (borrow in),
//                      d (8-bit difference), bout (borrow out of bit 7).
// Revision    : 1.0 - initial release
// ============================================================================
module Subtractor_8_bit (
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    input  wire logic       bin,
    output logic      [7:0] d,
    output logic            bout
);

    // w_br[i] is the borrow into bit i; w_br[8] leaves the slice.
    logic [8:0] w_br;

    assign w_br[0] = bin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign d[i]      = a[i] ^ b[i] ^ w_br[i];
        // Borrow when b exceeds a, or when the bits match and a borrow arrives.
        assign w_br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
    end

    assign bout = w_br[8];

endmodule : Subtractor_8_bit
`default_nettype wire

// File: rtl/subtractor_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_seq_ctrl
// Description : Multi-byte subtraction sequencer. Computes A - B - borrow_in
//               one byte per clock (LSB first) through one shared 8-bit
//               subtractor, carrying the borrow in a register between bytes.
//               Ports: clk, rst (async, active high),
//                      bus (slave modport: start/abort/A/B/borrow_in in,
//                           ready/busy/done/diff/borrow_out/zero out).
//               NBYTES legal range is 2..16.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_seq_ctrl
    import subtractor_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    subtractor_seq_ctrl_if.slave  bus
);

    localparam int               c_idx_w    = $clog2(NBYTES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBYTES - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [NBYTES-1:0][BYTE_W-1:0]   r_a;
    logic [NBYTES-1:0][BYTE_W-1:0]   r_b;
    logic [NBYTES-1:0][BYTE_W-1:0]   r_diff;
    logic [c_idx_w-1:0]              r_idx;
    logic                            r_borrow;
    logic                            r_zacc;
    logic                            r_borrow_out;
    logic                            r_zero;

    logic [BYTE_W-1:0]               w_a_byte;
    logic [BYTE_W-1:0]               w_b_byte;
    logic [BYTE_W-1:0]               w_sub_diff;
    logic                            w_sub_bout;
    logic                            w_sub_zero;
    logic [NBYTES-1:0]               w_byte_we;

    logic                            w_accept;
    logic                            w_abort;
    logic                            w_step;
    logic                            w_last;
    logic                            w_ready;
    logic                            w_busy;
    logic                            w_done;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_abort  = (r_state == S_RUN)  && bus.abort;
    // abort takes priority over the byte step, including on the last byte.
    assign w_step   = (r_state == S_RUN)  && !bus.abort;
    assign w_last   = (r_idx == c_last_idx);

    // ------------------------------------------------------------------
    // Byte datapath
    // ------------------------------------------------------------------
    assign w_a_byte = r_a[r_idx];
    assign w_b_byte = r_b[r_idx];

    Subtractor_8_bit u_sub8 (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .bin  (r_borrow),
        .d    (w_sub_diff),
        .bout (w_sub_bout)
    );

    assign w_sub_zero = (w_sub_diff == '0);

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte_we
        assign w_byte_we[i] = w_step && (r_idx == c_idx_w'(i));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, byte index, borrow chain and final flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_zacc       <= 1'b0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= bus.borrow_in;
            r_idx    <= '0;
            r_zacc   <= 1'b1;
        end else if (w_abort) begin
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_step) begin
            r_borrow <= w_sub_bout;
            r_zacc   <= r_zacc & w_sub_zero;
            if (w_last) begin
                // Index wraps to 0 so it never exceeds NBYTES-1.
                r_idx        <= '0;
                r_borrow_out <= w_sub_bout;
                r_zero       <= r_zacc & w_sub_zero;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Result register: one byte lane written per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
        end else if (w_abort) begin
            r_diff <= '0;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_byte_we[i]) begin
                    r_diff[i] <= w_sub_diff;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready      = w_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.zero       = r_zero;

endmodule : subtractor_seq_ctrl
`default_nettype wire

// File: tb/tb_subtractor_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_seq_ctrl
// Description : Self-checking bench for subtractor_seq_ctrl (NBYTES=4) with a
//               queue-based scoreboard of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    subtractor_seq_ctrl_if #(.NBYTES(NB)) bus ();

    subtractor_seq_ctrl #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        e.diff = full[W-1:0];
        e.bout = ({1'b0, a} < ({1'b0, b} + (W+1)'(bin)));
        e.zero = (e.diff == '0);
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ":ready"}, bus.ready, 1);
        check({tag, ":busy"},  bus.busy, 0);
        check({tag, ":done"},  bus.done, 0);
        check({tag, ":diff"},  bus.diff, 0);
        check({tag, ":bout"},  bus.borrow_out, 0);
        check({tag, ":zero"},  bus.zero, 0);
    endtask

    // One complete operation. hold_start keeps start high (with other
    // operands) throughout RUN to show it is ignored; with_abort asserts
    // abort together with start in IDLE, where start must win.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit hold_start, input bit with_abort, input string tag);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        bus.A         = a;
        bus.B         = b;
        bus.borrow_in = bin;
        bus.start     = 1'b1;
        bus.abort     = with_abort;
        sb.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check({tag, ":busy_after_accept"}, bus.busy, 1);
        if (hold_start) begin
            bus.A = ~a;
            bus.B = b ^ 32'h5A5A_A5A5;
        end else begin
            bus.start = 1'b0;
        end
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check({tag, ":done_latency"}, lat, NB);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ":diff"},        bus.diff, e.diff);
            check({tag, ":borrow_out"},  bus.borrow_out, e.bout);
            check({tag, ":zero"},        bus.zero, e.zero);
            check({tag, ":ready_in_done"}, bus.ready, 0);
        end else begin
            check({tag, ":done_seen"}, seen, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        check({tag, ":done_one_cycle"}, bus.done, 0);
        check({tag, ":ready_back"},     bus.ready, 1);
        if (hold_start) begin
            @(posedge clk);
            #1;
            check({tag, ":no_restart"}, bus.busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 0, "basic");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 0, "ripple");
        run_op(32'h0000_0100, 32'h0000_0000, 1'b1, 0, 0, "bin_1");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0, 0, "bin_2");

        // abort in IDLE must leave held results untouched
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("idle_abort:diff", bus.diff, 32'hFFFF_FFFF);
        check("idle_abort:bout", bus.borrow_out, 1);

        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 0, "equal");
        run_op(32'h0000_0009, 32'h0000_0004, 1'b0, 1, 0, "held_start");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1, "start_abort");

        // abort after two RUN edges (previous result leaves zero=0, use equal first)
        run_op(32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 0, 0, "equal_2");
        @(negedge clk);
        bus.A     = 32'h7777_FFFF;
        bus.B     = 32'h0000_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort:partial_diff", bus.diff, 32'h0000_FFFF);
        check("abort:busy_before",  bus.busy, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check_reset_outputs("abort");
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort:no_done", ndone, 0);

        // asynchronous reset in the middle of RUN
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 0, "pre_reset");
        @(negedge clk);
        bus.A     = 32'h1111_2222;
        bus.B     = 32'h0000_0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 0, "basic_after_reset");

        for (int n = 0; n < 5; n++) begin
            run_op(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 0, 0, "random");
        end

        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_subtractor_seq_ctrl
`default_nettype wire

// File: doc/subtractor_seq_ctrl.md
# subtractor_seq_ctrl

Multi-byte subtraction sequencer. It computes A − B − borrow_in on NBYTES-wide operands by driving one shared 8-bit ripple subtractor (Subtractor_8_bit), one byte per clock, least-significant byte first. Between bytes it keeps the borrow in a register. It is the sequencing layer between the ALU operand registers and the 8-bit subtract datapath, and replaces a wide combinational subtractor.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; accepted only while ready=1.
- abort  input  1  synchronous cancel of an operation in progress.
- A  input  8*NBYTES  minuend; sampled on the accepting edge.
- B  input  8*NBYTES  subtrahend; sampled on the accepting edge.
- borrow_in  input  1  initial borrow; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- diff  output  8*NBYTES  result register.
- borrow_out  output  1  final borrow from the most-significant byte.
- zero  output  1  high when the completed diff is all zeros.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: ready=1, busy=0, done=0, diff=0, borrow_out=0, zero=0. The operand latches, byte index and borrow register also reset to 0.
- IDLE:
  - If start=1, latch A, B and borrow_in; set idx=0 and zero accumulator=1; go to RUN.
  - If start=0, stay in IDLE.
- RUN, each cycle:
  - Feed byte idx of the latched A and B, plus the borrow register, to the subtractor.
  - Write its diff into byte idx of the diff register.
  - Borrow register ← subtractor borrow_out.
  - Zero accumulator ← zero accumulator AND (byte diff == 0).
  - idx ← idx+1.
  - When idx = NBYTES−1: borrow_out ← final borrow, zero ← final accumulator, go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE. diff, borrow_out and zero hold until the next accepted start, abort or reset.
- abort=1 in RUN: go to IDLE on that edge and clear diff, borrow_out and zero to 0. No done pulse is produced. abort has no effect in IDLE or DONE.
- start while not ready (RUN or DONE) is ignored; the request is not queued.
- start and abort together in IDLE: start wins.
- Arithmetic:
  - Result is A − B − borrow_in, taken modulo 2^(8·NBYTES).
  - borrow_out=1 exactly when A < B + borrow_in (unsigned).
  - idx is a $clog2(NBYTES)-bit counter and never exceeds NBYTES−1.

## Timing
- The accepting edge is E0. Bytes 0..NBYTES−1 are processed on edges E1..E_NBYTES.
- The full result is valid after edge E_NBYTES. done is high from E_NBYTES to E_NBYTES+1. ready returns after E_NBYTES+1.
- Throughput: one operation every NBYTES+2 cycles when start is held high.
- The subtractor is purely combinational inside one cycle; there is no pipeline register between the byte mux and the diff write.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock. The first accepted start after reset release behaves as a normal first operation.

## Structure
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One sub-module instance: Subtractor_8_bit, used as the byte datapath.
- The byte selection mux and the diff byte write-enable decode stay in this module.

## Test plan
All scenarios use NBYTES=4.
- Basic: A=0x00000005, B=0x00000003, borrow_in=0 → diff=0x00000002, borrow_out=0, zero=0. done pulses exactly 4 edges after the accepting edge, for one cycle.
- Full borrow ripple: A=0x00000000, B=0x00000001 → diff=0xFFFFFFFF, borrow_out=1, zero=0.
- Equal operands: A=B=0x12345678, borrow_in=0 → diff=0, borrow_out=0, zero=1.
- Initial borrow: A=0x00000100, B=0, borrow_in=1 → diff=0x000000FF, borrow_out=0. Second case: A=B=0, borrow_in=1 → diff=0xFFFFFFFF, borrow_out=1.
- Abort and ignored start:
  - Assert start again during RUN → no second operation starts.
  - Assert abort after 2 RUN edges → state is IDLE on the next edge, with diff=0, borrow_out=0, no done, and ready=1.
- Reset mid-RUN: assert rst asynchronously between edges → all outputs read their reset values before the next edge. After release, the basic case passes again.
